// File: rtl/sprite_dma_if.sv
// System-bus view of the sprite DMA engine: CPU-side bus inputs plus the
// engine's halt line and bus-master outputs that feed the sysbus muxes.
interface sprite_dma_if #(
  parameter int ADDR_N = 16,
  parameter int DATA_N = 8
);

  logic [ADDR_N-1:0] bus_addr;
  logic              bus_we;
  logic [DATA_N-1:0] bus_data;

  logic              rdy;
  logic              dma_en;
  logic [ADDR_N-1:0] dma_addr;
  logic              dma_we;
  logic [DATA_N-1:0] dma_data;

  // The DMA engine side.
  modport master (
    input  bus_addr, bus_we, bus_data,
    output rdy, dma_en, dma_addr, dma_we, dma_data
  );

  // The sysbus / CPU side that resolves the muxes and serves reads.
  modport slave (
    output bus_addr, bus_we, bus_data,
    input  rdy, dma_en, dma_addr, dma_we, dma_data
  );

endinterface

// File: rtl/sprite_dma.sv
// Sprite (OAM) DMA: a CPU write to DMA_REG halts the CPU and copies one
// 256-byte page to the PPU OAM data port, one read and one write per byte.
module sprite_dma #(
  parameter int                ADDR_N   = 16,
  parameter int                DATA_N   = 8,
  parameter logic [ADDR_N-1:0] DMA_REG  = 'h4014,
  parameter logic [ADDR_N-1:0] OAM_DATA = 'h2004
) (
  input logic          clk,
  input logic          n_reset,
  sprite_dma_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t     state;
  logic [7:0] page;
  logic [7:0] cnt;
  logic       odd;
  logic       trigger;

  assign trigger = bus.bus_we && (bus.bus_addr == DMA_REG);

  // Source address stays inside the page: only the low byte ever advances.
  function automatic logic [ADDR_N-1:0] src_addr(input logic [7:0] pg,
                                                 input logic [7:0] idx);
    return ADDR_N'({pg, idx});
  endfunction

  // NOTE: every flop here, outputs included, is assigned with <= so all
  // of them see the pre-edge values of state/cnt/odd in the same clock.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state        <= IDLE;
      page         <= 8'h00;
      cnt          <= 8'h00;
      odd          <= 1'b0;
      bus.rdy      <= 1'b1;
      bus.dma_en   <= 1'b0;
      bus.dma_we   <= 1'b0;
      bus.dma_addr <= '0;
      bus.dma_data <= '0;
    end else begin
      odd <= ~odd;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            page    <= bus.bus_data[7:0];
            cnt     <= 8'h00;
            state   <= HALT;
            bus.rdy <= 1'b0;
          end
        end

        // The first READ must land on an even cycle; an odd HALT goes
        // straight there, an even one spends a dead ALIGN cycle first.
        HALT: begin
          if (odd) begin
            state        <= READ;
            bus.dma_en   <= 1'b1;
            bus.dma_addr <= src_addr(page, cnt);
          end else begin
            state <= ALIGN;
          end
        end

        ALIGN: begin
          state        <= READ;
          bus.dma_en   <= 1'b1;
          bus.dma_addr <= src_addr(page, cnt);
        end

        // dma_data doubles as the byte buffer: it captures the slave's
        // combinational read data and is presented during WRITE.
        READ: begin
          state        <= WRITE;
          bus.dma_we   <= 1'b1;
          bus.dma_addr <= OAM_DATA;
          bus.dma_data <= bus.bus_data;
        end

        WRITE: begin
          bus.dma_we   <= 1'b0;
          bus.dma_data <= '0;
          if (cnt == 8'hff) begin
            state        <= IDLE;
            bus.rdy      <= 1'b1;
            bus.dma_en   <= 1'b0;
            bus.dma_addr <= '0;
          end else begin
            cnt          <= cnt + 8'd1;
            state        <= READ;
            bus.dma_addr <= src_addr(page, cnt + 8'd1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_dma.sv
// Directed bench for sprite_dma: sysbus mux and memory model in the bench,
// expected OAM traffic queued at each trigger and popped as the DUT drives it.
module tb_sprite_dma;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_data;

  sprite_dma_if #(.ADDR_N(16), .DATA_N(8)) bus ();

  sprite_dma #(
    .ADDR_N  (16),
    .DATA_N  (8),
    .DMA_REG (16'h4014),
    .OAM_DATA(16'h2004)
  ) u_dut (
    .clk    (clk),
    .n_reset(n_reset),
    .bus    (bus.master)
  );

  always #5 clk = ~clk;

  // Boot ROM at page ff with reset vector ff00, work RAM pattern elsewhere.
  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (a == 16'hfffc) return 8'h00;
    if (a == 16'hfffd) return 8'hff;
    if (a[15:8] == 8'hff) return a[7:0] ^ 8'h3c;
    return a[7:0] ^ 8'h5a ^ (a[15:8] - 8'h02);
  endfunction

  always_comb begin
    bus.bus_addr = bus.dma_en ? bus.dma_addr : cpu_addr;
    bus.bus_we   = bus.dma_en ? bus.dma_we : cpu_we;
    if (bus.dma_en)
      bus.bus_data = bus.dma_we ? bus.dma_data : mem_rd(bus.dma_addr);
    else
      bus.bus_data = cpu_we ? cpu_data : mem_rd(cpu_addr);
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] rd_q[$];
  logic [7:0]  wr_q[$];
  logic [7:0]  oam[256];
  logic [15:0] last_rd;
  logic        model_odd;
  int          low_cnt;
  int          wr_idx;
  int          rst_at_write = 0;
  bit          seen_rdy;
  bit          first_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    logic [15:0] exp_a;
    logic [7:0]  exp_d;
    if (bus.rdy === 1'b0) low_cnt++;
    seen_rdy = (bus.rdy === 1'b1);
    if (bus.dma_en === 1'b1 && bus.dma_we === 1'b0) begin
      if (first_rd) begin
        check("first_read_parity", {31'd0, model_odd}, 32'd0);
        first_rd = 1'b0;
      end
      exp_a = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hxxxx;
      check("read_addr", {16'd0, bus.dma_addr}, {16'd0, exp_a});
      last_rd = bus.dma_addr;
    end
    if (bus.dma_we === 1'b1) begin
      exp_d = (wr_q.size() > 0) ? wr_q.pop_front() : 8'hxx;
      check("write_addr", {16'd0, bus.dma_addr}, 32'h2004);
      check("write_data", {24'd0, bus.dma_data}, {24'd0, exp_d});
      oam[wr_idx & 255] = bus.dma_data;
      wr_idx++;
    end
    if (bus.dma_en === 1'b0)
      check("idle_outputs_zero", {7'd0, bus.dma_we, bus.dma_addr, bus.dma_data}, 32'd0);
  endtask

  // Sample mid-cycle, optionally assert reset before the edge, then advance.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      if (rst_at_write != 0 && wr_idx == rst_at_write) begin
        n_reset      = 1'b0;
        rst_at_write = 0;
      end
      @(posedge clk);
      model_odd = n_reset ? ~model_odd : 1'b0;
      #1;
    end
  endtask

  task automatic trigger(input logic [7:0] pg, input bit inject);
    for (int i = 0; i < 256; i++) begin
      rd_q.push_back({pg, i[7:0]});
      wr_q.push_back(mem_rd({pg, i[7:0]}));
    end
    low_cnt  = 0;
    wr_idx   = 0;
    first_rd = 1'b1;
    cpu_we   = 1'b1;
    cpu_addr = 16'h4014;
    cpu_data = pg;
    step(1);
    if (inject) begin
      cpu_data = 8'h07;
      step(1);
    end
    cpu_we   = 1'b0;
    cpu_addr = 16'h0000;
    cpu_data = 8'h00;
  endtask

  task automatic wait_done(input int exp_low);
    int n = 0;
    while (!(seen_rdy && low_cnt > 0) && n < 700) begin
      step(1);
      n++;
    end
    check("rdy_low_cycles", low_cnt, exp_low);
    check("reads_left", rd_q.size(), 32'd0);
    check("writes_left", wr_q.size(), 32'd0);
  endtask

  initial begin
    int exp_low;
    n_reset   = 1'b0;
    cpu_addr  = 16'h0000;
    cpu_we    = 1'b0;
    cpu_data  = 8'h00;
    model_odd = 1'b0;
    last_rd   = 16'h0000;

    // Reset values and parity flop behaviour.
    step(3);
    check("reset_rdy", {31'd0, bus.rdy}, 32'd1);
    check("reset_dma_en", {31'd0, bus.dma_en}, 32'd0);
    check("reset_dma_we", {31'd0, bus.dma_we}, 32'd0);
    check("reset_dma_addr", {16'd0, bus.dma_addr}, 32'd0);
    check("reset_dma_data", {24'd0, bus.dma_data}, 32'd0);
    check("reset_odd", {31'd0, u_dut.odd}, {31'd0, model_odd});
    n_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      check("odd_toggle", {31'd0, u_dut.odd}, {31'd0, model_odd});
    end

    // Even-parity start: no ALIGN cycle.
    while (model_odd != 1'b0) step(1);
    trigger(8'h02, 1'b0);
    wait_done(513);

    // Odd-parity start: one ALIGN cycle, first READ on even parity.
    while (model_odd != 1'b1) step(1);
    trigger(8'h02, 1'b0);
    wait_done(514);

    // Boot ROM page, no wrap into page 00.
    exp_low = model_odd ? 514 : 513;
    trigger(8'hff, 1'b0);
    wait_done(exp_low);
    check("rom_last_read", {16'd0, last_rd}, 32'hffff);
    check("rom_vec_lo", {24'd0, oam[8'hfc]}, 32'h00);
    check("rom_vec_hi", {24'd0, oam[8'hfd]}, 32'hff);

    // Reset during the 100th WRITE.
    trigger(8'h02, 1'b0);
    rst_at_write = 100;
    for (int i = 0; i < 400 && n_reset; i++) step(1);
    check("midrst_rdy", {31'd0, bus.rdy}, 32'd1);
    check("midrst_dma_en", {31'd0, bus.dma_en}, 32'd0);
    check("midrst_dma_we", {31'd0, bus.dma_we}, 32'd0);
    check("midrst_writes", wr_idx, 32'd100);
    rd_q.delete();
    wr_q.delete();
    step(2);
    n_reset = 1'b1;
    step(1);
    exp_low = model_odd ? 514 : 513;
    trigger(8'h02, 1'b0);
    wait_done(exp_low);

    // Non-triggers: wrong address write, then a read of DMA_REG.
    cpu_we   = 1'b1;
    cpu_addr = 16'h4015;
    cpu_data = 8'h02;
    step(1);
    cpu_we   = 1'b0;
    cpu_addr = 16'h4014;
    step(1);
    cpu_addr = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("no_trigger_rdy", {31'd0, bus.rdy}, 32'd1);
    end

    // Write of 07 to DMA_REG while page 03 is in flight is ignored.
    exp_low = model_odd ? 514 : 513;
    trigger(8'h03, 1'b1);
    wait_done(exp_low);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sprite_dma.md
# sprite_dma

Sprite (OAM) DMA engine on the system bus. A CPU write of a page number to the DMA register halts the CPU through `rdy`. The engine then becomes bus master and copies 256 bytes from that page to the PPU OAM data port, one read cycle and one write cycle per byte. Its source data comes from sysbus slaves that drive `sysbus.data` combinationally in the same cycle, such as the boot ROM and work RAM. Its own outputs feed the sysbus address/data/write muxes.

## Interface

- `DMA_REG`, default `'h4014`: CPU write address that triggers a transfer.
- `OAM_DATA`, default `'h2004`: destination address written once per byte.
- `ADDR_N`, default 16: bus address width.
- `DATA_N`, default 8: bus data width.

Ports:

- `clk` in 1: system clock; one clock; reset is synchronous and active-low.
- `n_reset` in 1: synchronous, active-low reset.
- `bus_addr` in ADDR_N: current sysbus address, as driven by the CPU when idle.
- `bus_we` in 1: CPU write strobe.
- `bus_data` in DATA_N: resolved sysbus data (CPU write data, or slave read data).
- `rdy` out 1: CPU ready; 0 holds the CPU.
- `dma_en` out 1: engine owns the bus; sysbus muxes select `dma_*`.
- `dma_addr` out ADDR_N: bus address while `dma_en`.
- `dma_we` out 1: bus write strobe while `dma_en`.
- `dma_data` out DATA_N: bus write data.

## Operation

- **States:** IDLE, HALT, ALIGN, READ, WRITE.
- **Registers:**
  - `page[7:0]`, `cnt[7:0]`, `buf[7:0]`.
  - `odd`: a cycle-parity flop that toggles every clock from reset, independent of state.
- **IDLE:**
  - Trigger condition: `bus_we && bus_addr == DMA_REG`.
  - On trigger: `page <= bus_data[7:0]`, `cnt <= 0`, next state HALT.
  - All other bus traffic is ignored.
- **HALT:** one cycle.
  - If `odd == 1`, next state is READ.
  - Otherwise, next state is ALIGN.
  - This guarantees the first READ occurs with `odd == 0`.
- **ALIGN:** one dead cycle, then READ.
- **READ:**
  - `dma_addr = {page, cnt}`.
  - `buf <= bus_data` at the clock edge ending the cycle.
  - Next state WRITE.
- **WRITE:**
  - `dma_addr = OAM_DATA`, `dma_data = buf`, `dma_we = 1`.
  - If `cnt == 'hff`, next state is IDLE.
  - Otherwise, `cnt <= cnt + 1` (8-bit, wraps) and next state is READ.
- **Outputs:**
  - `rdy = 0` in HALT, ALIGN, READ and WRITE; 1 in IDLE.
  - `dma_en = 1` in READ and WRITE only. In HALT and ALIGN the CPU still owns the bus but is held.
  - `dma_we = 1` in WRITE only.
  - `dma_addr` and `dma_data` are 0 outside READ and WRITE.
  - All outputs are decoded from registered state and registers, with no combinational path from bus inputs.
- **Writes to `DMA_REG` while not IDLE:** ignored. `page` is unchanged and there is no restart.
- **Reads of `DMA_REG`:** no effect (`bus_we = 0`).
- **Source page:** `page` may be any value, including `'hff`. The source address wraps only within the page; the high byte is never incremented.

## Timing

- **Reset values:**
  - `n_reset = 0` at an edge gives state IDLE and `page = cnt = buf = 0`, `odd = 0`.
  - Outputs: `rdy = 1`, `dma_en = 0`, `dma_we = 0`, `dma_addr = 0`, `dma_data = 0`.
- **Reset mid-transfer:** same values on the next cycle. No further OAM writes occur and no partial state is retained.
- **Start latency:** trigger write in cycle T; `rdy = 0` from T+1.
- **Transfer length:** `rdy` stays low for 513 cycles if `odd == 0` in cycle T, or 514 cycles if `odd == 1` in cycle T.
- **Release:** `rdy` returns to 1 in the cycle after the final WRITE.
- **Back-to-back transfers:** a new trigger is accepted in the first IDLE cycle.
- **Read data sampling:** slaves must present read data in the same cycle as `dma_addr`. `buf` samples it at the end of READ, which requires a single-cycle, combinational-output slave.
- **Byte order:** OAM writes are in ascending source order: byte `i` is written in the WRITE cycle following the READ of `{page, i}`.

## Test plan

1. **Reset:**
   - Stimulus: hold `n_reset = 0` for 3 cycles, then release.
   - Required: all outputs at reset values, and `odd` alternating 0,1,0,… from the release.
2. **Even-parity start:**
   - Stimulus: write `'h02` to `'h4014` in a cycle with `odd = 0`. Memory model holds `'h0200+i = i ^ 'h5a`.
   - Required: `rdy` low for exactly 513 cycles, with no ALIGN cycle.
   - Required: 256 writes to `'h2004` with data `'h5a, 'h5b, …, 'ha5`, in order.
3. **Odd-parity start:**
   - Stimulus: same trigger in a cycle with `odd = 1`.
   - Required: `rdy` low for 514 cycles.
   - Required: first READ with `odd = 0` and `dma_addr = 'h0200`.
4. **Boot ROM page:**
   - Stimulus: trigger with `'hff`, ROM model attached.
   - Required: reads `'hff00`…`'hffff`.
   - Required: the OAM byte at index `'hfc` equals `'h00` and at `'hfd` equals `'hff` (reset vector); last read address is `'hffff` with no wrap to `'h0000`.
5. **Reset mid-transfer:**
   - Stimulus: assert `n_reset = 0` during the 100th WRITE.
   - Required: next cycle `rdy = 1`, `dma_en = 0`, `dma_we = 0`.
   - Required: a new trigger then starts at `{page, 'h00}`.
6. **Non-triggers and ignored writes:**
   - Stimulus: a write to `'h4015`, then a read of `'h4014`.
   - Required: no DMA starts.
   - Stimulus: a write to `'h4014` with data `'h07` during an active transfer from page `'h03`.
   - Required: the transfer completes from page `'h03` unchanged.
